// File: rtl/c3lib_ckg_pkg.sv
// Shared types and helpers for the clock-gater request controller.
// The EN_LAT default matches the gater's two-stage bitsync plus its latch.
package c3lib_ckg_pkg;

    localparam int unsigned CKG_EN_LAT_DEF = 3;

    typedef enum logic [4:0] {
        ST_OFF   = 5'b00001,
        ST_WAKE  = 5'b00010,
        ST_ON    = 5'b00100,
        ST_HOLD  = 5'b01000,
        ST_DRAIN = 5'b10000
    } ckg_state_e;

    function automatic int unsigned ckg_cnt_w(
        input int unsigned en_lat,
        input int unsigned idle_cnt
    );
        int unsigned m;
        m = (en_lat > idle_cnt) ? en_lat : idle_cnt;
        if (m < 1) m = 1;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/c3lib_ckg_req_ctrl.sv
// Aggregates clock requests and drives the gater enable with idle hysteresis,
// returning an ack only once the gated clock is guaranteed to be running.
module c3lib_ckg_req_ctrl
    import c3lib_ckg_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned EN_LAT    = CKG_EN_LAT_DEF,
    parameter int unsigned IDLE_CNT  = 8,
    parameter bit          RESET_VAL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               force_on,
    output logic               clk_en,
    output logic               clk_ack,
    output logic               gated_off,
    output logic               busy
);

    if (EN_LAT == 0 || NUM_REQ == 0) begin : g_param_err
        $error("c3lib_ckg_req_ctrl: EN_LAT and NUM_REQ must be nonzero");
    end

    localparam int unsigned CW = ckg_cnt_w(EN_LAT, IDLE_CNT);
    localparam logic [CW-1:0] EN_LD = CW'(EN_LAT - 1);
    localparam logic [CW-1:0] IDLE_LD = CW'((IDLE_CNT == 0) ? 0 : IDLE_CNT - 1);
    localparam ckg_state_e RST_ST = RESET_VAL ? ST_ON : ST_OFF;

    ckg_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_en_q, clk_en_d;
    logic          clk_ack_q, clk_ack_d;
    logic          gated_off_q, gated_off_d;
    logic          busy_q, busy_d;
    logic          any_req;

    always_comb begin
        any_req = (|req) | force_on;
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_OFF: begin
                if (any_req) begin
                    state_d = ST_WAKE;
                    cnt_d   = EN_LD;
                end
            end
            ST_WAKE: begin
                if (cnt_q == '0) state_d = ST_ON;
                else             cnt_d   = cnt_q - CW'(1);
            end
            ST_ON: begin
                if (!any_req) begin
                    if (IDLE_CNT == 0) begin
                        state_d = ST_DRAIN;
                        cnt_d   = EN_LD;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = IDLE_LD;
                    end
                end
            end
            ST_HOLD: begin
                if (any_req) begin
                    state_d = ST_ON;
                end else if (cnt_q == '0) begin
                    state_d = ST_DRAIN;
                    cnt_d   = EN_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) state_d = ST_OFF;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase

        // Decode from the next state so outputs line up with state_q.
        clk_en_d    = (state_d == ST_WAKE) || (state_d == ST_ON)
                   || (state_d == ST_HOLD);
        clk_ack_d   = (state_d == ST_ON) || (state_d == ST_HOLD);
        gated_off_d = (state_d == ST_OFF);
        busy_d      = (state_d == ST_WAKE) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RST_ST;
            cnt_q       <= '0;
            clk_en_q    <= RESET_VAL;
            clk_ack_q   <= RESET_VAL;
            gated_off_q <= ~RESET_VAL;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clk_en_q    <= clk_en_d;
            clk_ack_q   <= clk_ack_d;
            gated_off_q <= gated_off_d;
            busy_q      <= busy_d;
        end
    end

    assign clk_en    = clk_en_q;
    assign clk_ack   = clk_ack_q;
    assign gated_off = gated_off_q;
    assign busy      = busy_q;

endmodule
